ps2_key_event_ctrl: RTL and testbench
=====================================

// Module: ps2_key_event_ctrl
// PURPOSE
//  Sequencer between the PS/2 frame receiver and the consumers (ASCII lookup, 7-seg, counters).
//  Consumes validated scan-code bytes and runs the set-2 prefix protocol (E0 extended, F0 break).
//  Suppresses typematic repeats, tracks the held key and counts distinct presses.
//  Queues decoded key events in a small FIFO with a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH   4     event FIFO entries; power of 2, >=2
//  CNT_W        8     width of press_cnt; wraps modulo 2^CNT_W
//  TIMEOUT_CYC  50000 clk cycles a prefix state may wait for its next byte
//  EMIT_REPEAT  0     1: queue typematic repeats with rpt=1; 0: drop them
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  resetn     in   1      asynchronous active-low reset
//  rx_valid   in   1      one-cycle pulse, rx_data holds a parity-checked byte
//  rx_data    in   8      received scan-code byte
//  evt_valid  out  1      FIFO non-empty
//  evt_ready  in   1      consumer accepts head event when evt_valid&evt_ready
//  evt_code   out  8      head event scan code, no prefix
//  evt_ext    out  1      head event was E0-prefixed
//  evt_brk    out  1      head event is a release
//  evt_rpt    out  1      head event is a typematic repeat
//  held_valid out  1      a key is currently held (drives seg_en)
//  held_code  out  9      {ext,code} of held key
//  press_cnt  out  CNT_W  count of distinct new presses
//  err_pulse  out  1      one-cycle pulse on protocol error or timeout
//  overflow   out  1      sticky: an event was dropped on full FIFO
//  ovf_clr    in   1      clears overflow; wins over same-cycle set
// BEHAVIOUR
//  Reset: state=S_IDLE, FIFO empty, held_valid=0, held_code=0, press_cnt=0, err_pulse=0,
//   overflow=0, timeout counter=0. Reset asserted mid-sequence discards any prefix.
//  FSM, advances only on rx_valid. id={ext,code}.
//   S_IDLE: E0->S_E0; F0->S_F0; 00/FF->err, stay; else make(ext=0).
//   S_E0:   F0->S_E0F0; E0->stay, no error; 00/FF->err,S_IDLE; else make(ext=1),S_IDLE.
//   S_F0:   E0/F0/00/FF->err,S_IDLE; else break(ext=0),S_IDLE.
//   S_E0F0: E0/F0/00/FF->err,S_IDLE; else break(ext=1),S_IDLE.
//  Timeout: counter clears on every rx_valid and in S_IDLE. In prefix states it counts.
//   At TIMEOUT_CYC-1 with no byte: err_pulse, S_IDLE.
//  Make with held_valid && id==held_code: repeat.
//   No count. Pushed with rpt=1 only if EMIT_REPEAT.
//  Other make: held_code<=id, held_valid<=1, press_cnt+=1 (wrap), push {code,ext,brk=0,rpt=0}.
//  Break: push {code,ext,brk=1,rpt=0}. If id==held_code, held_valid<=0.
//   A break for another key leaves the held key unchanged.
//  FIFO: push is registered. An event is visible on evt_valid the cycle after rx_valid.
//   Head outputs are stable while evt_valid && !evt_ready.
//   Head outputs are don't-care when empty.
//   Full with no pop: push dropped, overflow<=1, FSM and held state still update.
//   Full with pop in the same cycle: push accepted.
//   Empty: a push and evt_ready in the same cycle do not bypass; the pop is ignored.
//  err_pulse is high for exactly 1 cycle per error. A timeout and an error byte cannot coincide.
// TESTING
//  1C, then F0 1C -> make{1C,e0,b0}, break{1C,b1}; press_cnt=1; held_valid 1 then 0.
//  E0 75, E0 F0 75 -> make{75,ext1}, break{75,ext1,brk1}; held_code=0x175 while held.
//  1C x4 (typematic), EMIT_REPEAT=0 -> one event, press_cnt=1.
//   With EMIT_REPEAT=1 -> 4 events, last 3 have rpt=1.
//  evt_ready=0, 5 makes of distinct codes (DEPTH 4) -> 4 queued, overflow=1.
//   Then ovf_clr -> overflow=0; drain yields the first 4 codes in order.
//  F0 then idle TIMEOUT_CYC cycles -> err_pulse once, state S_IDLE; next 1C decodes as a make.
//  F0 F0 -> err_pulse, no event. resetn low after E0 -> next 1C is make with ext=0, press_cnt=1.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Sits between the PS/2 frame receiver and the key consumers. It takes
// validated set-2 scan-code bytes, resolves the E0 (extended) and F0 (break)
// prefixes, suppresses typematic repeats of the held key, counts distinct
// presses and queues decoded key events in a small FIFO.
//
// Ports
//   clk        system clock, everything on posedge
//   resetn     asynchronous active-low reset
//   rx_valid   one-cycle strobe: rx_data holds a parity-checked byte
//   rx_data    received scan-code byte
//   evt_valid  FIFO non-empty
//   evt_ready  consumer takes the head event when evt_valid && evt_ready
//   evt_code   head event scan code (prefix bytes stripped)
//   evt_ext    head event was E0-prefixed
//   evt_brk    head event is a key release
//   evt_rpt    head event is a typematic repeat (only when EMIT_REPEAT=1)
//   held_valid a key is currently held
//   held_code  {ext,code} of the held key
//   press_cnt  count of distinct new presses, wraps
//   err_pulse  one-cycle pulse on a protocol error or prefix timeout
//   overflow   sticky: an event was dropped because the FIFO was full
//   ovf_clr    clears overflow; beats a same-cycle set
//   dbg_state  current decoder state (0 idle, 1 E0, 2 F0, 3 E0 F0)
//
// Event handshake: an event leaves the FIFO on every rising edge where
// evt_valid && evt_ready; the head outputs hold steady while evt_valid is
// high and evt_ready is low, and are meaningless while evt_valid is low.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int EMIT_REPEAT = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic             evt_rpt,
    output logic             held_valid,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_pulse,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    state_t state_q, next_state;
    logic [TO_W-1:0] to_cnt_q;

    logic        err_now;
    logic        dec_valid;
    logic        dec_ext;
    logic        dec_brk;
    logic        bad_byte;
    logic [8:0]  dec_id;
    logic        is_repeat;
    logic        is_new_make;
    logic        push;
    logic [10:0] push_data;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    // ------------------------------------------------------------------
    // Prefix decoder: next state and decoded event
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state_q;
        err_now    = 1'b0;
        dec_valid  = 1'b0;
        dec_ext    = 1'b0;
        dec_brk    = 1'b0;
        bad_byte   = (rx_data == 8'h00) || (rx_data == 8'hFF);
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hE0)      next_state = S_E0;
                    else if (rx_data == 8'hF0) next_state = S_F0;
                    else if (bad_byte)         err_now    = 1'b1;
                    else                       dec_valid  = 1'b1;
                end
                S_E0: begin
                    if (rx_data == 8'hF0) begin
                        next_state = S_E0F0;
                    end else if (rx_data == 8'hE0) begin
                        // a duplicated E0 is tolerated
                        next_state = S_E0;
                    end else if (bad_byte) begin
                        err_now    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        dec_valid  = 1'b1;
                        dec_ext    = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_F0, S_E0F0: begin
                    next_state = S_IDLE;
                    if (bad_byte || rx_data == 8'hE0 || rx_data == 8'hF0) begin
                        err_now = 1'b1;
                    end else begin
                        dec_valid = 1'b1;
                        dec_brk   = 1'b1;
                        dec_ext   = (state_q == S_E0F0);
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
            // prefix waited too long for its follow-up byte
            err_now    = 1'b1;
            next_state = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Event classification
    // ------------------------------------------------------------------
    always_comb begin
        dec_id      = {dec_ext, rx_data};
        is_repeat   = dec_valid && !dec_brk && held_valid && (dec_id == held_code);
        is_new_make = dec_valid && !dec_brk && !is_repeat;
        push        = is_new_make || (dec_valid && dec_brk) ||
                      (is_repeat && (EMIT_REPEAT != 0));
        push_data   = {rx_data, dec_ext, dec_brk, is_repeat};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= next_state;
            err_pulse <= err_now;
            if (rx_valid || state_q == S_IDLE || err_now) to_cnt_q <= '0;
            else                                          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Held key and press counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_valid <= 1'b0;
            held_code  <= '0;
            press_cnt  <= '0;
        end else begin
            if (is_new_make) begin
                held_valid <= 1'b1;
                held_code  <= dec_id;
                press_cnt  <= press_cnt + CNT_W'(1);
            end else if (dec_valid && dec_brk && dec_id == held_code) begin
                held_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO. A pop on an empty FIFO is ignored, so a same-cycle push
    // never bypasses; a pop on a full FIFO frees the slot for the push.
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = evt_ready && (count_q != '0);
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_clr)                         overflow <= 1'b0;
            else if (push && fifo_full && !pop)  overflow <= 1'b1;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_code  = mem[rd_ptr][10:3];
    assign evt_ext   = mem[rd_ptr][2];
    assign evt_brk   = mem[rd_ptr][1];
    assign evt_rpt   = mem[rd_ptr][0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl. Two instances share the stimulus: one drops
// typematic repeats with an 8-bit press counter, the other emits repeats and
// uses a 3-bit counter so the wrap is reached. A reference model written in
// terms of "pending prefix flags", a held key and an event queue predicts
// every output after each clock.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic clk = 1'b0;
    logic resetn;
    logic rx_valid;
    logic [7:0] rx_data;
    logic evt_ready;
    logic ovf_clr;

    logic       a_evt_valid, a_evt_ext, a_evt_brk, a_evt_rpt;
    logic [7:0] a_evt_code;
    logic       a_held_valid, a_err_pulse, a_overflow;
    logic [8:0] a_held_code;
    logic [7:0] a_press_cnt;
    logic [1:0] a_dbg_state;

    logic       b_evt_valid, b_evt_ext, b_evt_brk, b_evt_rpt;
    logic [7:0] b_evt_code;
    logic       b_held_valid, b_err_pulse, b_overflow;
    logic [8:0] b_held_code;
    logic [2:0] b_press_cnt;
    logic [1:0] b_dbg_state;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(TO), .EMIT_REPEAT(0)) u_a (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .evt_valid(a_evt_valid), .evt_ready(evt_ready), .evt_code(a_evt_code),
        .evt_ext(a_evt_ext), .evt_brk(a_evt_brk), .evt_rpt(a_evt_rpt),
        .held_valid(a_held_valid), .held_code(a_held_code), .press_cnt(a_press_cnt),
        .err_pulse(a_err_pulse), .overflow(a_overflow), .ovf_clr(ovf_clr),
        .dbg_state(a_dbg_state)
    );

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(3), .TIMEOUT_CYC(TO), .EMIT_REPEAT(1)) u_b (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .evt_valid(b_evt_valid), .evt_ready(evt_ready), .evt_code(b_evt_code),
        .evt_ext(b_evt_ext), .evt_brk(b_evt_brk), .evt_rpt(b_evt_rpt),
        .held_valid(b_held_valid), .held_code(b_held_code), .press_cnt(b_press_cnt),
        .err_pulse(b_err_pulse), .overflow(b_overflow), .ovf_clr(ovf_clr),
        .dbg_state(b_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    // event entries are {code[7:0], ext, brk, rpt}
    logic [10:0] exp_q_a[$];
    logic [10:0] exp_q_b[$];

    bit       m_pend;       // some prefix byte is pending
    bit       m_ext;        // an E0 is pending
    bit       m_brk;        // an F0 is pending
    int       m_wait;       // idle cycles spent with a prefix pending
    bit       m_held_v;
    bit [8:0] m_held;
    int       m_presses;
    bit       m_ovf_a, m_ovf_b;
    bit       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_ext = 0; m_brk = 0; m_wait = 0;
        m_held_v = 0; m_held = '0; m_presses = 0;
        m_ovf_a = 0; m_ovf_b = 0; m_err = 0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic drop_prefix();
        m_pend = 0; m_ext = 0; m_brk = 0; m_wait = 0;
    endtask

    // Predict the effect of the coming clock edge given the current inputs.
    task automatic model_step();
        bit ev, e_ext, e_brk;
        bit push_a, push_b, set_a, set_b;
        logic [10:0] item;
        logic [8:0] id;
        ev = 0; e_ext = 0; e_brk = 0; m_err = 0;
        push_a = 0; push_b = 0; set_a = 0; set_b = 0;
        item = '0;

        if (evt_ready && exp_q_a.size() > 0) void'(exp_q_a.pop_front());
        if (evt_ready && exp_q_b.size() > 0) void'(exp_q_b.pop_front());

        if (rx_valid) begin
            m_wait = 0;
            if (rx_data == 8'h00 || rx_data == 8'hFF) begin
                m_err = 1; drop_prefix();
            end else if (rx_data == 8'hE0) begin
                if (m_brk) begin m_err = 1; drop_prefix(); end
                else begin m_pend = 1; m_ext = 1; end
            end else if (rx_data == 8'hF0) begin
                if (m_brk) begin m_err = 1; drop_prefix(); end
                else begin m_pend = 1; m_brk = 1; end
            end else begin
                ev = 1; e_ext = m_ext; e_brk = m_brk;
                drop_prefix();
            end
        end else if (m_pend) begin
            if (m_wait == TO - 1) begin m_err = 1; drop_prefix(); end
            else m_wait++;
        end

        if (ev) begin
            id   = {e_ext, rx_data};
            item = {rx_data, e_ext, e_brk, 1'b0};
            if (!e_brk) begin
                if (m_held_v && id == m_held) begin
                    push_b = 1; item[0] = 1'b1;
                end else begin
                    m_held_v = 1; m_held = id; m_presses++;
                    push_a = 1; push_b = 1;
                end
            end else begin
                push_a = 1; push_b = 1;
                if (id == m_held) m_held_v = 0;
            end
        end

        if (push_a) begin
            if (exp_q_a.size() == DEPTH) set_a = 1;
            else exp_q_a.push_back(item);
        end
        if (push_b) begin
            if (exp_q_b.size() == DEPTH) set_b = 1;
            else exp_q_b.push_back(item);
        end
        if (ovf_clr) begin m_ovf_a = 0; m_ovf_b = 0; end
        else begin
            if (set_a) m_ovf_a = 1;
            if (set_b) m_ovf_b = 1;
        end
    endtask

    task automatic compare_all();
        check("a_valid", a_evt_valid, exp_q_a.size() != 0);
        if (exp_q_a.size() != 0)
            check("a_head", {a_evt_code, a_evt_ext, a_evt_brk, a_evt_rpt}, exp_q_a[0]);
        check("b_valid", b_evt_valid, exp_q_b.size() != 0);
        if (exp_q_b.size() != 0)
            check("b_head", {b_evt_code, b_evt_ext, b_evt_brk, b_evt_rpt}, exp_q_b[0]);
        check("a_held_v", a_held_valid, m_held_v);
        check("b_held_v", b_held_valid, m_held_v);
        check("a_held_c", a_held_code, m_held);
        check("b_held_c", b_held_code, m_held);
        check("a_cnt", a_press_cnt, m_presses % 256);
        check("b_cnt", b_press_cnt, m_presses % 8);
        check("a_err", a_err_pulse, m_err);
        check("b_err", b_err_pulse, m_err);
        check("a_ovf", a_overflow, m_ovf_a);
        check("b_ovf", b_overflow, m_ovf_b);
        check("a_idle", a_dbg_state == 2'd0, !m_pend);
        check("b_idle", b_dbg_state == 2'd0, !m_pend);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        rx_valid  = v;
        rx_data   = d;
        evt_ready = rdy;
        ovf_clr   = clr;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rx_valid = 0; rx_data = 8'h00; evt_ready = 0; ovf_clr = 0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        compare_all();
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int err_seen;
    logic [7:0] codes [4];

    initial begin
        resetn = 1'b1;
        rx_valid = 0; rx_data = 0; evt_ready = 0; ovf_clr = 0;
        codes[0] = 8'h1C; codes[1] = 8'h75; codes[2] = 8'h15; codes[3] = 8'h6B;
        @(negedge clk);
        do_reset();
        check("rst_cnt", a_press_cnt, 0);
        check("rst_held", a_held_code, 0);

        // make then break
        send(8'h1C);
        check("s1_held_on", a_held_valid, 1);
        send(8'hF0); send(8'h1C);
        check("s1_held_off", a_held_valid, 0);
        check("s1_cnt", a_press_cnt, 1);
        idle(2);

        // extended make/break
        do_reset();
        send(8'hE0); send(8'h75);
        check("s2_held", a_held_code, 9'h175);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(2);

        // typematic repeats
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1; rx_data = 8'h1C; evt_ready = 0; ovf_clr = 0;
            cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        end
        check("s3_cnt", a_press_cnt, 1);
        check("s3_b_rpt", {b_evt_code, b_evt_rpt}, {8'h1C, 1'b0});
        idle(6);

        // overflow with consumer stalled
        do_reset();
        cyc(1'b1, 8'h15, 1'b0, 1'b0);
        cyc(1'b1, 8'h16, 1'b0, 1'b0);
        cyc(1'b1, 8'h1D, 1'b0, 1'b0);
        cyc(1'b1, 8'h24, 1'b0, 1'b0);
        cyc(1'b1, 8'h2D, 1'b0, 1'b0);
        check("s4_ovf", a_overflow, 1);
        check("s4_cnt", a_press_cnt, 5);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("s4_ovf_clr", a_overflow, 0);
        check("s4_head", a_evt_code, 8'h15);
        idle(5);

        // prefix timeout
        do_reset();
        send(8'hF0);
        err_seen = 0;
        for (int i = 0; i < TO + 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            err_seen += int'(a_err_pulse);
        end
        check("s5_err_once", err_seen, 1);
        check("s5_state", a_dbg_state, 0);
        send(8'h1C);
        check("s5_make", a_held_code, 9'h01C);

        // F0 F0 is a protocol error
        do_reset();
        send(8'hF0); send(8'hF0);
        check("s6_err", a_err_pulse, 1);
        check("s6_empty", a_evt_valid, 0);

        // reset discards a pending E0
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h1C);
        check("s7_held", a_held_code, 9'h01C);
        check("s7_cnt", a_press_cnt, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [7:0] d;
            bit v;
            if ($urandom_range(0, 999) < 2) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < TO + 2; k++)
                    cyc(1'b0, 8'h00, $urandom_range(0, 1) == 1, 1'b0);
                continue;
            end
            r = $urandom_range(0, 11);
            if (r < 2)       d = 8'hE0;
            else if (r < 4)  d = 8'hF0;
            else if (r == 4) d = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
            else if (r < 10) d = codes[$urandom_range(0, 3)];
            else             d = 8'($urandom_range(1, 254));
            v = ($urandom_range(0, 9) < 4);
            cyc(v, d, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
